// File: rtl/ibex_sec_ldst_seq_pkg.sv
// Shared types and constants for the secure load/store sequencer.
// Holds the sequencer state encoding, share-count defaults and a share
// selection helper used to pick one 32-bit store share out of a packed vector.
package ibex_sec_ldst_seq_pkg;

    typedef enum logic [1:0] {
        SEC_LDST_IDLE = 2'd0,
        SEC_LDST_REQ  = 2'd1,
        SEC_LDST_WAIT = 2'd2,
        SEC_LDST_FIN  = 2'd3
    } sec_ldst_state_e;

    localparam int unsigned SEC_NSHARES      = 2;
    localparam int unsigned SEC_SHARE_STRIDE = 4;
    localparam int unsigned SEC_MAX_SHARES   = 4;

    // Return share idx (32 bits) of a packed share vector sized for the maximum share count.
    function automatic logic [31:0] sec_share_sel(
        input logic [SEC_MAX_SHARES*32-1:0] shares,
        input logic [1:0]                   idx
    );
        logic [31:0] sel_s;
        sel_s = 32'h0000_0000;
        for (int k = 0; k < SEC_MAX_SHARES; k++) begin
            if (idx == 2'(k)) begin
                sel_s = shares[k*32 +: 32];
            end else begin
                sel_s = sel_s;
            end
        end
        return sel_s;
    endfunction

endpackage

// File: rtl/ibex_sec_ldst_seq.sv
// Secure load/store sequencer: expands one masked access into NShares word
// accesses at base, base+4, ..., drives the LSU req/gnt/rvalid handshake and
// gathers loaded shares. Optional macro SEC_LDST_ZEROIZE_EN clears the share
// buffer after completion and blanks rdata_o / lsu_wdata_o when not valid so
// no share value lingers on a bus.
module ibex_sec_ldst_seq
    import ibex_sec_ldst_seq_pkg::*;
#(
    parameter int unsigned NShares   = SEC_NSHARES,
    parameter int unsigned AddrWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   we_i,
    input  logic [AddrWidth-1:0]   base_addr_i,
    input  logic [NShares*32-1:0]  wdata_i,
    output logic                   busy_o,
    output logic                   lsu_req_o,
    output logic                   lsu_we_o,
    output logic [AddrWidth-1:0]   lsu_addr_o,
    output logic [31:0]            lsu_wdata_o,
    input  logic                   lsu_gnt_i,
    input  logic                   lsu_rvalid_i,
    input  logic [31:0]            lsu_rdata_i,
    input  logic                   lsu_err_i,
    output logic [NShares*32-1:0]  rdata_o,
    output logic                   done_o,
    output logic                   err_o
);

    localparam logic [1:0] LastIdx = 2'(NShares - 1);

    sec_ldst_state_e                 state_r;
    logic [1:0]                      idx_r;
    logic                            we_r;
    logic                            err_r;
    logic [SEC_MAX_SHARES*32-1:0]    wdata_r;
    logic [SEC_MAX_SHARES*32-1:0]    wdata_pad_s;
    logic [NShares*32-1:0]           buf_r;
    logic [NShares*32-1:0]           buf_nxt_s;

    logic                            busy_r;
    logic                            req_r;
    logic                            lsu_we_r;
    logic [AddrWidth-1:0]            addr_r;
    logic [31:0]                     lsu_wdata_r;
    logic                            done_r;
    logic                            err_out_r;

    // Zero-extend the incoming store shares to the helper's fixed width.
    always_comb begin
        wdata_pad_s                  = '0;
        wdata_pad_s[NShares*32-1:0]  = wdata_i;
    end

    // Next share-buffer value: capture load responses into slot idx while waiting.
    always_comb begin
        buf_nxt_s = buf_r;
        if (state_r == SEC_LDST_WAIT && lsu_rvalid_i && !we_r) begin
            for (int k = 0; k < int'(NShares); k++) begin
                if (idx_r == 2'(k)) begin
                    buf_nxt_s[k*32 +: 32] = lsu_rdata_i;
                end else begin
                    buf_nxt_s[k*32 +: 32] = buf_r[k*32 +: 32];
                end
            end
        end else begin
`ifdef SEC_LDST_ZEROIZE_EN
            if (state_r == SEC_LDST_FIN) begin
                buf_nxt_s = '0;
            end else begin
                buf_nxt_s = buf_r;
            end
`else
            buf_nxt_s = buf_r;
`endif
        end
    end

    // Share buffer register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_r <= '0;
        end else begin
            buf_r <= buf_nxt_s;
        end
    end

    // Sequencer FSM; every output is registered and set on the transition into its state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= SEC_LDST_IDLE;
            idx_r       <= 2'd0;
            we_r        <= 1'b0;
            err_r       <= 1'b0;
            wdata_r     <= '0;
            busy_r      <= 1'b0;
            req_r       <= 1'b0;
            lsu_we_r    <= 1'b0;
            addr_r      <= '0;
            lsu_wdata_r <= 32'h0000_0000;
            done_r      <= 1'b0;
            err_out_r   <= 1'b0;
        end else begin
            case (state_r)
                SEC_LDST_IDLE: begin
                    done_r    <= 1'b0;
                    err_out_r <= 1'b0;
                    if (start_i) begin
                        we_r    <= we_i;
                        wdata_r <= wdata_pad_s;
                        idx_r   <= 2'd0;
                        busy_r  <= 1'b1;
                        if (base_addr_i[1:0] != 2'b00) begin
                            // Misaligned: report immediately, never touch the bus.
                            err_r     <= 1'b1;
                            done_r    <= 1'b1;
                            err_out_r <= 1'b1;
                            state_r   <= SEC_LDST_FIN;
                        end else begin
                            err_r       <= 1'b0;
                            req_r       <= 1'b1;
                            lsu_we_r    <= we_i;
                            addr_r      <= base_addr_i;
                            lsu_wdata_r <= wdata_i[31:0];
                            state_r     <= SEC_LDST_REQ;
                        end
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= SEC_LDST_IDLE;
                    end
                end
                SEC_LDST_REQ: begin
                    // Request stays stable until granted; rvalid here is ignored.
                    if (lsu_gnt_i) begin
                        req_r   <= 1'b0;
`ifdef SEC_LDST_ZEROIZE_EN
                        lsu_wdata_r <= 32'h0000_0000;
`endif
                        state_r <= SEC_LDST_WAIT;
                    end else begin
                        state_r <= SEC_LDST_REQ;
                    end
                end
                SEC_LDST_WAIT: begin
                    if (lsu_rvalid_i) begin
                        if (lsu_err_i) begin
                            err_r     <= 1'b1;
                            done_r    <= 1'b1;
                            err_out_r <= 1'b1;
                            state_r   <= SEC_LDST_FIN;
                        end else if (idx_r == LastIdx) begin
                            done_r    <= 1'b1;
                            err_out_r <= err_r;
                            state_r   <= SEC_LDST_FIN;
                        end else begin
                            idx_r       <= idx_r + 2'd1;
                            addr_r      <= addr_r + AddrWidth'(SEC_SHARE_STRIDE);
                            lsu_wdata_r <= sec_share_sel(wdata_r, idx_r + 2'd1);
                            req_r       <= 1'b1;
                            state_r     <= SEC_LDST_REQ;
                        end
                    end else begin
                        state_r <= SEC_LDST_WAIT;
                    end
                end
                SEC_LDST_FIN: begin
                    done_r    <= 1'b0;
                    err_out_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= SEC_LDST_IDLE;
                end
                default: begin
                    req_r     <= 1'b0;
                    done_r    <= 1'b0;
                    err_out_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= SEC_LDST_IDLE;
                end
            endcase
        end
    end

`ifdef SEC_LDST_ZEROIZE_EN
    logic                  fin_entry_s;
    logic [NShares*32-1:0] rdata_r;

    // Detect the cycle in which the FSM moves into FIN.
    always_comb begin
        fin_entry_s = 1'b0;
        if (state_r == SEC_LDST_IDLE) begin
            fin_entry_s = start_i && (base_addr_i[1:0] != 2'b00);
        end else if (state_r == SEC_LDST_WAIT) begin
            fin_entry_s = lsu_rvalid_i && (lsu_err_i || idx_r == LastIdx);
        end else begin
            fin_entry_s = 1'b0;
        end
    end

    // Gathered shares are visible only during the completion cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_r <= '0;
        end else if (fin_entry_s) begin
            rdata_r <= buf_nxt_s;
        end else begin
            rdata_r <= '0;
        end
    end

    assign rdata_o = rdata_r;
`else
    assign rdata_o = buf_r;
`endif

    assign busy_o      = busy_r;
    assign lsu_req_o   = req_r;
    assign lsu_we_o    = lsu_we_r;
    assign lsu_addr_o  = addr_r;
    assign lsu_wdata_o = lsu_wdata_r;
    assign done_o      = done_r;
    assign err_o       = err_out_r;

endmodule

// File: tb/tb_ibex_sec_ldst_seq.sv
// Directed table-driven bench for ibex_sec_ldst_seq (NShares = 2), plus a
// hand-written asynchronous-reset-in-WAIT sequence.
module tb_ibex_sec_ldst_seq;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] base_addr_i = 32'h0;
    logic [63:0] wdata_i = 64'h0;
    logic        busy_o;
    logic        lsu_req_o;
    logic        lsu_we_o;
    logic [31:0] lsu_addr_o;
    logic [31:0] lsu_wdata_o;
    logic        lsu_gnt_i = 1'b0;
    logic        lsu_rvalid_i = 1'b0;
    logic [31:0] lsu_rdata_i = 32'h0;
    logic        lsu_err_i = 1'b0;
    logic [63:0] rdata_o;
    logic        done_o;
    logic        err_o;

    int checks = 0;
    int failures = 0;

    ibex_sec_ldst_seq #(.NShares(2), .AddrWidth(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .we_i         (we_i),
        .base_addr_i  (base_addr_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .lsu_req_o    (lsu_req_o),
        .lsu_we_o     (lsu_we_o),
        .lsu_addr_o   (lsu_addr_o),
        .lsu_wdata_o  (lsu_wdata_o),
        .lsu_gnt_i    (lsu_gnt_i),
        .lsu_rvalid_i (lsu_rvalid_i),
        .lsu_rdata_i  (lsu_rdata_i),
        .lsu_err_i    (lsu_err_i),
        .rdata_o      (rdata_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [31:0] base;
        logic [63:0] wdata;
        int          gnt_delay;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        err_first;
        logic        mid_start;
        int          exp_lat;
        int          exp_nreq;
        logic        exp_err;
        logic        chk_rdata;
        logic [63:0] exp_rdata;
        logic [63:0] exp_rdata_z;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   nreq;
        int   waited;
        int   lat;
        logic pend;
        logic got_done;
        logic [63:0] exp_rd;
        nreq = 0; waited = 0; lat = 0; pend = 1'b0; got_done = 1'b0;
`ifdef SEC_LDST_ZEROIZE_EN
        exp_rd = v.exp_rdata_z;
`else
        exp_rd = v.exp_rdata;
`endif
        @(negedge clk_i);
        start_i = 1'b1; we_i = v.we; base_addr_i = v.base; wdata_i = v.wdata;
        for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
            @(negedge clk_i);
            start_i = v.mid_start && (cyc == 2);
            lsu_gnt_i = 1'b0; lsu_rvalid_i = 1'b0; lsu_err_i = 1'b0; lsu_rdata_i = 32'h0;
            if (done_o) begin
                got_done = 1'b1;
                lat = cyc;
                chk("err_o", 128'(err_o), 128'(v.exp_err));
                chk("busy_fin", 128'(busy_o), 128'(1'b1));
                if (v.chk_rdata) chk("rdata_o", 128'(rdata_o), 128'(exp_rd));
            end else begin
                chk("busy_active", 128'(busy_o), 128'(1'b1));
                if (lsu_req_o) begin
                    chk("lsu_addr", 128'(lsu_addr_o), 128'((nreq == 0) ? v.exp_a0 : v.exp_a1));
                    chk("lsu_we", 128'(lsu_we_o), 128'(v.we));
                    if (v.we) chk("lsu_wdata", 128'(lsu_wdata_o),
                                  128'((nreq == 0) ? v.wdata[31:0] : v.wdata[63:32]));
                    if (waited >= ((nreq == 0) ? v.gnt_delay : 0)) begin
                        lsu_gnt_i = 1'b1; pend = 1'b1; waited = 0; nreq++;
                    end else begin
                        waited++;
                    end
                end else begin
`ifdef SEC_LDST_ZEROIZE_EN
                    chk("wdata_idle_zero", 128'(lsu_wdata_o), 128'(32'h0));
`endif
                    if (pend) begin
                        lsu_rvalid_i = 1'b1;
                        lsu_rdata_i = (nreq == 1) ? v.rd0 : v.rd1;
                        lsu_err_i = v.err_first && (nreq == 1);
                        pend = 1'b0;
                    end
                end
            end
        end
        chk("latency", 128'(lat), 128'(v.exp_lat));
        chk("num_req", 128'(nreq), 128'(v.exp_nreq));
        start_i = 1'b0;
        @(negedge clk_i);
        chk("done_pulse_end", 128'(done_o), 128'(1'b0));
        chk("busy_after", 128'(busy_o), 128'(1'b0));
        chk("req_after", 128'(lsu_req_o), 128'(1'b0));
`ifdef SEC_LDST_ZEROIZE_EN
        chk("rdata_zero_after", 128'(rdata_o), 128'(64'h0));
`endif
        if (v.mid_start) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk_i);
                chk("no_second_done", 128'(done_o), 128'(1'b0));
            end
        end
    endtask

    initial begin
        vecs[0] = '{we: 1'b0, base: 32'h0000_1000, wdata: 64'h0, gnt_delay: 0,
                    rd0: 32'hA5A5_A5A5, rd1: 32'h5A5A_5A5A, err_first: 1'b0, mid_start: 1'b0,
                    exp_lat: 5, exp_nreq: 2, exp_err: 1'b0, chk_rdata: 1'b1,
                    exp_rdata: 64'h5A5A_5A5A_A5A5_A5A5, exp_rdata_z: 64'h5A5A_5A5A_A5A5_A5A5,
                    exp_a0: 32'h0000_1000, exp_a1: 32'h0000_1004};
        vecs[1] = '{we: 1'b1, base: 32'h0000_2000, wdata: 64'h2222_2222_1111_1111, gnt_delay: 3,
                    rd0: 32'h0, rd1: 32'h0, err_first: 1'b0, mid_start: 1'b0,
                    exp_lat: 8, exp_nreq: 2, exp_err: 1'b0, chk_rdata: 1'b1,
                    exp_rdata: 64'h5A5A_5A5A_A5A5_A5A5, exp_rdata_z: 64'h0,
                    exp_a0: 32'h0000_2000, exp_a1: 32'h0000_2004};
        vecs[2] = '{we: 1'b0, base: 32'h0000_3002, wdata: 64'h0, gnt_delay: 0,
                    rd0: 32'h0, rd1: 32'h0, err_first: 1'b0, mid_start: 1'b0,
                    exp_lat: 1, exp_nreq: 0, exp_err: 1'b1, chk_rdata: 1'b1,
                    exp_rdata: 64'h5A5A_5A5A_A5A5_A5A5, exp_rdata_z: 64'h0,
                    exp_a0: 32'h0, exp_a1: 32'h0};
        vecs[3] = '{we: 1'b0, base: 32'h0000_1000, wdata: 64'h0, gnt_delay: 0,
                    rd0: 32'hDEAD_BEEF, rd1: 32'h0, err_first: 1'b1, mid_start: 1'b0,
                    exp_lat: 3, exp_nreq: 1, exp_err: 1'b1, chk_rdata: 1'b0,
                    exp_rdata: 64'h0, exp_rdata_z: 64'h0,
                    exp_a0: 32'h0000_1000, exp_a1: 32'h0000_1004};
        vecs[4] = '{we: 1'b0, base: 32'hFFFF_FFFC, wdata: 64'h0, gnt_delay: 0,
                    rd0: 32'h0123_4567, rd1: 32'h89AB_CDEF, err_first: 1'b0, mid_start: 1'b1,
                    exp_lat: 5, exp_nreq: 2, exp_err: 1'b0, chk_rdata: 1'b1,
                    exp_rdata: 64'h89AB_CDEF_0123_4567, exp_rdata_z: 64'h89AB_CDEF_0123_4567,
                    exp_a0: 32'hFFFF_FFFC, exp_a1: 32'h0000_0000};

        // Reset state
        #3;
        chk("rst_busy", 128'(busy_o), 128'(1'b0));
        chk("rst_req", 128'(lsu_req_o), 128'(1'b0));
        chk("rst_done", 128'(done_o), 128'(1'b0));
        chk("rst_err", 128'(err_o), 128'(1'b0));
        chk("rst_addr", 128'(lsu_addr_o), 128'(32'h0));
        chk("rst_wdata", 128'(lsu_wdata_o), 128'(32'h0));
        chk("rst_rdata", 128'(rdata_o), 128'(64'h0));
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Asynchronous reset while waiting for a response
        @(negedge clk_i);
        start_i = 1'b1; we_i = 1'b0; base_addr_i = 32'h0000_4000; wdata_i = 64'h0;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("rstseq_req", 128'(lsu_req_o), 128'(1'b1));
        chk("rstseq_addr", 128'(lsu_addr_o), 128'(32'h0000_4000));
        lsu_gnt_i = 1'b1;
        @(negedge clk_i);
        lsu_gnt_i = 1'b0;
        chk("rstseq_wait_busy", 128'(busy_o), 128'(1'b1));
        chk("rstseq_wait_noreq", 128'(lsu_req_o), 128'(1'b0));
        rst_ni = 1'b0;
        lsu_rvalid_i = 1'b1;
        lsu_rdata_i = 32'hCAFE_F00D;
        #1;
        chk("rstseq_busy_low", 128'(busy_o), 128'(1'b0));
        chk("rstseq_req_low", 128'(lsu_req_o), 128'(1'b0));
        chk("rstseq_done_low", 128'(done_o), 128'(1'b0));
        @(negedge clk_i);
        rst_ni = 1'b1;
        lsu_rvalid_i = 1'b0;
        lsu_rdata_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rstseq_no_done", 128'(done_o), 128'(1'b0));
            chk("rstseq_idle", 128'(busy_o), 128'(1'b0));
        end
        run_vec(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ibex_sec_ldst_seq.md
Name: ibex_sec_ldst_seq

Overview:
- Multi-cycle sequencer for the custom secure load/store instructions (OPCODE_SEC_LDST). It consumes the decoded request from the ID stage.
- The decoder computes the base address from SEC_IMM_B_I or SEC_IMM_B_S. The sequencer expands one instruction into NShares word accesses at base, base+4, and so on, one access per share.
- It drives the LSU request/grant/rvalid handshake and gathers loaded shares for writeback. It stalls ID via busy_o while active.

Parameters:
- NShares, 2: number of masked shares per secure access; legal range 2..4.
- AddrWidth, 32: address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  decoder request, one-cycle pulse; accepted only in IDLE.
- we_i  in  1  1 = secure store, 0 = secure load; sampled with start_i.
- base_addr_i  in  AddrWidth  base address (rs1 + sec imm); sampled with start_i.
- wdata_i  in  NShares*32  store shares; share k is bits [32k+31:32k]; sampled with start_i.
- busy_o  out  1  high in every state except IDLE.
- lsu_req_o  out  1  data-memory request.
- lsu_we_o  out  1  write enable of the current request.
- lsu_addr_o  out  AddrWidth  word address of the current request.
- lsu_wdata_o  out  32  store data of the current request.
- lsu_gnt_i  in  1  request granted.
- lsu_rvalid_i  in  1  response valid.
- lsu_rdata_i  in  32  load response data.
- lsu_err_i  in  1  bus error; qualified by lsu_rvalid_i.
- rdata_o  out  NShares*32  gathered load shares; valid while done_o is high.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  error flag; valid while done_o is high.

Behaviour:
- Reset values: all outputs 0; state IDLE; share index 0; share buffer 0; error flag 0.
- IDLE:
  - On start_i, register we, base and wdata, and clear idx and err.
  - If base[1:0] != 0 (misaligned), set err and go to FIN; no LSU request is issued.
  - Otherwise go to REQ.
- REQ:
  - lsu_req_o = 1; lsu_addr_o = base + 4*idx, wrapping modulo 2^AddrWidth; lsu_we_o = we; lsu_wdata_o = share idx.
  - Request signals are held stable until lsu_gnt_i.
  - On lsu_gnt_i, go to WAIT; lsu_req_o drops in the next cycle.
- WAIT:
  - On lsu_rvalid_i, a load writes lsu_rdata_i into buffer slot idx.
  - If lsu_err_i is set: set err and go to FIN. Remaining shares are not issued.
  - Else if idx == NShares-1: go to FIN.
  - Else: idx++ and go to REQ.
- Grant and rvalid in the same cycle:
  - The grant cycle moves REQ to WAIT.
  - An rvalid arriving in that same grant cycle is ignored; rvalid is only sampled in WAIT.
  - The LSU contract guarantees rvalid no earlier than one cycle after gnt.
- FIN: done_o = 1 and err_o = err for exactly one cycle; rdata_o shows the buffer; next state IDLE.
- Latency with gnt in the request cycle and rvalid in the following cycle:
  - start_i to done_o is 2*NShares + 1 cycles: 5 for NShares = 2.
  - For a misaligned start, done_o follows start_i by 1 cycle.
- start_i is ignored when state != IDLE; the decoder must hold it off using busy_o.
- rdata_o outside FIN holds the last buffer value, unless SEC_LDST_ZEROIZE_EN is defined.
- A store leaves the buffer unchanged. A load with an error keeps the shares received before the error; the remaining slots are stale.
- Reset mid-operation:
  - Deasserting rst_ni forces IDLE immediately, asynchronously.
  - lsu_req_o drops; any outstanding response is dropped; no done_o is produced.

Optional Feature:
- Macro: SEC_LDST_ZEROIZE_EN.
- Defined:
  - The share buffer clears to 0 in the cycle after FIN.
  - rdata_o is forced to 0 whenever done_o = 0.
  - lsu_wdata_o is forced to 0 whenever lsu_req_o = 0.
  - Purpose: no share value lingers on a bus, avoiding share-recombining transitions.
- Undefined: the buffer and lsu_wdata_o hold their last values; this saves the gating logic.

Decomposition:
- Add to ibex_pkg:
  - sec_ldst_state_e enum {SEC_LDST_IDLE, SEC_LDST_REQ, SEC_LDST_WAIT, SEC_LDST_FIN}, 2 bits.
  - Parameter SEC_NSHARES = 2.
  - Parameter SEC_SHARE_STRIDE = 4.
- No sub-module: the FSM, the address adder and the share buffer stay in one module.

Test Plan:
- Load, NShares = 2, base 0x1000, gnt immediate, rvalid one cycle later with rdata 0xA5A5A5A5 then 0x5A5A5A5A -> requests to 0x1000 then 0x1004, lsu_we_o = 0; done_o at start+5; rdata_o = {0x5A5A5A5A, 0xA5A5A5A5}; err_o = 0.
- Store, wdata {0x22222222, 0x11111111}, base 0x2000, gnt delayed 3 cycles on the first request -> addr, wdata and we held stable until gnt; second request is 0x2004/0x22222222; done_o at start+8.
- Base 0x3002 -> no lsu_req_o; done_o = 1 and err_o = 1 one cycle after start.
- Load, lsu_err_i on the first rvalid -> only one request issued (0x1000); done_o with err_o = 1 in the next cycle.
- Base 0xFFFFFFFC -> second request goes to 0x00000000; start_i pulsed mid-operation is ignored, so there is a single done_o.
- rst_ni low while in WAIT -> busy_o, lsu_req_o and done_o are 0 immediately; a following start completes normally.
- Additional case, SEC_LDST_ZEROIZE_EN defined: lsu_wdata_o = 0 between requests; rdata_o = 0 one cycle after done_o.
